// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with majority-vote bit sampling, framing check and optional parity.
// Ports: iClk clock, iRst sync active-high reset, iRxSerial async serial line (idle high),
//        oRxData last word, oRxValid one-cycle result pulse, oFrameErr stop bit low,
//        oParityErr parity mismatch, oBusy frame in progress.
// Macro UART_RX_PARITY_EN adds a parity bit after the data bits.
module uart_rx_ext #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iRxSerial,
    output logic [DATA_BITS-1:0] oRxData,
    output logic                 oRxValid,
    output logic                 oFrameErr,
    output logic                 oParityErr,
    output logic                 oBusy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] C_S0   = CW'(H - 1);
    localparam logic [CW-1:0] C_S1   = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] C_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] D_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);
    localparam logic          ODD    = PARITY_ODD != 0;
`ifdef UART_RX_PARITY_EN
    localparam logic          PAR_EN = 1'b1;
`else
    localparam logic          PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                 state, next;
    logic                   sync1, sync2, prev_line;
    logic [CW-1:0]          c;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   v0, v1, bit_now, at_dec, at_end;
    logic                   frame_acc, parity_acc, parity_err;

    assign bit_now    = (v0 & v1) | (v0 & sync2) | (v1 & sync2);
    assign at_dec     = c == C_DEC;
    assign at_end     = c == C_END;
    assign oRxValid   = state == DONE;
    assign oBusy      = state inside {START, DATA, PARITY, STOP};
    assign oParityErr = PAR_EN & parity_err;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (prev_line && !sync2) next = START;
            START:   if (at_dec && bit_now) next = IDLE;
                     else if (at_end) next = DATA;
            DATA:    if (at_end && idx == D_LAST) next = PAR_EN ? PARITY : STOP;
            PARITY:  if (at_end) next = STOP;
            // Leave on the last stop decision so a start edge right after it is not missed.
            STOP:    if (at_dec && idx == S_LAST) next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev_line  <= 1'b1;
            c          <= '0;
            idx        <= '0;
            shift      <= '0;
            v0         <= 1'b1;
            v1         <= 1'b1;
            frame_acc  <= 1'b0;
            parity_acc <= 1'b0;
            parity_err <= 1'b0;
            oRxData    <= '0;
            oFrameErr  <= 1'b0;
        end else begin
            sync1     <= iRxSerial;
            sync2     <= sync1;
            prev_line <= sync2;
            state     <= next;
            c         <= (state == IDLE || next == IDLE || next == DONE || at_end) ? '0 : c + 1'b1;
            idx       <= (next != state) ? '0 : (at_end ? idx + 1'b1 : idx);
            if (c == C_S0) v0 <= sync2;
            if (c == C_S1) v1 <= sync2;
            if (state == START) begin
                frame_acc  <= 1'b0;
                parity_acc <= 1'b0;
            end
            if (state == DATA && at_dec) shift <= {bit_now, shift[DATA_BITS-1:1]};
            if (state == PARITY && at_dec) parity_acc <= bit_now ^ (^shift) ^ ODD;
            if (state == STOP && at_dec && !bit_now) frame_acc <= 1'b1;
            if (next == DONE) begin
                oRxData    <= shift;
                oFrameErr  <= frame_acc | ~bit_now;
                parity_err <= parity_acc;
            end
        end
    end
endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CLK_FREQ, 125_000_000, clock frequency in Hz.
- BAUD_RATE, 115_200, line rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, clock cycles per bit; legal values ≥ 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- iClk, input, 1, sole clock.
- iRst, input, 1, reset; synchronous, active-high.
- iRxSerial, input, 1, asynchronous serial line; idle high.
- oRxData, output, DATA_BITS, last received word.
- oRxValid, output, 1, one-cycle pulse: word and flags are valid.
- oFrameErr, output, 1, a stop bit was sampled low.
- oParityErr, output, 1, parity mismatch.
- oBusy, output, 1, a frame is in progress.

REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 iRxSerial SHALL pass through a two-flop synchronizer before any use.
REQ-005 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-006 IDLE SHALL move to START only on a synchronized high-to-low transition. A line held low SHALL NOT start a frame.
REQ-007 Bit-period counter c:
- counts 0..CLKS_PER_BIT-1 in each bit state;
- c=0 is the first cycle in START;
- c wraps to 0 on every bit boundary.
REQ-008 Each bit SHALL be decided by a 2-of-3 majority vote of the synchronized line, with H = CLKS_PER_BIT/2 (integer division):
- samples taken at c = H-1, H and H+1;
- the decision is made at c = H+1.
REQ-009 START transitions:
- decided bit = 1 → false start; return to IDLE, no output pulse.
- decided bit = 0 → enter DATA at the next bit boundary.
REQ-010 DATA SHALL shift in DATA_BITS bits, LSB first, then go to PARITY (macro defined) or STOP (macro undefined).
REQ-011 STOP SHALL check STOP_BITS bits. Any stop bit decided low SHALL set the frame-error result.
REQ-012 After the last stop-bit decision, the FSM SHALL enter DONE immediately, without waiting for the bit end, so the receiver can resync on the next start edge.
REQ-013 DONE SHALL last exactly one cycle and then return to IDLE. In that cycle:
- oRxValid = 1;
- oRxData, oFrameErr and oParityErr are updated.
REQ-014 oRxData and both error flags SHALL hold their values until the next DONE.
REQ-015 oBusy SHALL be 1 in START, DATA, PARITY and STOP, and 0 otherwise.
REQ-016 A frame with a framing error (including break: all-zero data, stop low) SHALL still pulse oRxValid and report the received data.
REQ-017 Latency: oRxValid SHALL rise (1+DATA_BITS+P+STOP_BITS-1)·CLKS_PER_BIT + H + 2 cycles after the start edge, with P = 1 if parity is compiled in, else 0. Verification fixes this exact figure.

Reset
REQ-018 Reset SHALL force the following, regardless of state (mid-frame included):
- FSM to IDLE;
- c, bit index and shift register to 0;
- synchronizer flops to 1;
- oRxData = 0; oRxValid, oFrameErr, oParityErr and oBusy = 0.
REQ-019 After reset, reception SHALL resume only on a fresh high-to-low edge.

Configuration
REQ-020 Macro UART_RX_PARITY_EN, when defined:
- adds the PARITY state, one bit after the data bits;
- the expected bit is the XOR of the data bits, inverted when PARITY_ODD = 1;
- a mismatch sets oParityErr at DONE.
REQ-021 When UART_RX_PARITY_EN is undefined:
- no parity bit is expected;
- PARITY is unreachable;
- oParityErr is tied to 0, and the port remains.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-022 Frame 0x55, valid stop bit → one-cycle oRxValid with oRxData=0x55, oFrameErr=0, oParityErr=0, at the REQ-017 cycle.
REQ-023 4-cycle low glitch on an idle line → no oRxValid; oBusy returns to 0 by START c=H+2.
REQ-024 Frame 0xA3 with stop bit driven low → oRxValid=1, oRxData=0xA3, oFrameErr=1. The held-low line produces no new frame until it returns high.
REQ-025 Macro defined, even parity: 0xA3 with parity bit 1 → oParityErr=1; with parity bit 0 → oParityErr=0.
REQ-026 iRst pulsed during data bit 3, then frame 0x3C sent → all outputs 0 after reset; next pulse carries oRxData=0x3C with no errors.
REQ-027 DATA_BITS=7, STOP_BITS=2, back-to-back frames 0x7F then 0x00 → exactly two oRxValid pulses, data 0x7F then 0x00, no errors.
